// File: rtl/mod_port_pkg.sv
// Shared types and helpers for the mod_port convolution engine.
// - config_t: one record holding every engine parameter.
// - state_t : engine FSM states.
// - cw()    : $clog2 that never returns 0, so 1-deep dimensions still get a 1-bit counter.
// - act_addr / wgt_addr: flat word addresses used by the host loader and the engine.
package mod_port_pkg;

  typedef struct packed {
    int data_width;
    int fm_width;
    int fm_height;
    int in_ch;
    int out_ch;
    int kernel_size;
    int out_shift;
  } config_t;

  localparam config_t DEFAULT_CFG = '{
    data_width : 16,
    fm_width   : 8,
    fm_height  : 8,
    in_ch      : 2,
    out_ch     : 4,
    kernel_size: 3,
    out_shift  : 0
  };

  typedef enum logic [1:0] {IDLE, COMPUTE, FLUSH, DONE} state_t;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // activation word for map position (x,y), input channel ci
  function automatic int act_addr(input int x, input int y, input int ci,
                                  input int w, input int cin);
    return (y * w + x) * cin + ci;
  endfunction

  // weight word for output channel ch, kernel tap (ky,kx), input channel ci
  function automatic int wgt_addr(input int ch, input int ky, input int kx, input int ci,
                                  input int k, input int cin);
    return ((ch * k + ky) * k + kx) * cin + ci;
  endfunction

endpackage

// File: rtl/mod_port_if.sv
// Host-side bus of the mod_port engine.
// master: host/driver (load port, control, consumes results)
// slave : engine (drives ready, results, status)
// Load: a_input/a_valid/a_ready address, b_input/b_valid/b_ready data,
//       int_mem_we / overlap_cache_we target select, b_zero stores 0.
// Control: data_ready, start. Status: running, fsm_done.
// Results: output_data/valid tagged with output_x/y/ch.
interface mod_port_if #(
  parameter int DATA_WIDTH         = 16,
  parameter int FEATURE_MAP_WIDTH  = 8,
  parameter int FEATURE_MAP_HEIGHT = 8,
  parameter int OUTPUT_NB_CHANNELS = 4
) ();
  import mod_port_pkg::*;

  localparam int XW  = cw(FEATURE_MAP_WIDTH);
  localparam int YW  = cw(FEATURE_MAP_HEIGHT);
  localparam int CHW = cw(OUTPUT_NB_CHANNELS);

  logic                  int_mem_we;
  logic                  overlap_cache_we;
  logic                  b_zero;
  logic                  data_ready;
  logic                  start;
  logic [DATA_WIDTH-1:0] a_input;
  logic                  a_valid;
  logic                  a_ready;
  logic [DATA_WIDTH-1:0] b_input;
  logic                  b_valid;
  logic                  b_ready;
  logic [DATA_WIDTH-1:0] output_data;
  logic                  output_valid;
  logic [XW-1:0]         output_x;
  logic [YW-1:0]         output_y;
  logic [CHW-1:0]        output_ch;
  logic                  running;
  logic                  fsm_done;

  modport master (
    output int_mem_we, overlap_cache_we, b_zero, data_ready, start,
    output a_input, a_valid, b_input, b_valid,
    input  a_ready, b_ready,
    input  output_data, output_valid, output_x, output_y, output_ch,
    input  running, fsm_done
  );

  modport slave (
    input  int_mem_we, overlap_cache_we, b_zero, data_ready, start,
    input  a_input, a_valid, b_input, b_valid,
    output a_ready, b_ready,
    output output_data, output_valid, output_x, output_y, output_ch,
    output running, fsm_done
  );

endinterface

// File: rtl/mod_port_mac.sv
// Signed multiply-accumulate with registered, shifted result.
// clk, rst : clock, synchronous active-high reset
// clr      : first tap of an output; accumulator restarts from this product
// en       : accumulate this cycle
// last     : final tap; registers the result and raises out_valid next cycle
// a, b     : signed operands; out_data/out_valid: result and 1-cycle qualifier
// Build option MOD_PORT_SAT_EN: saturate the shifted accumulator to DW bits
// instead of keeping its low DW bits.
module mod_port_mac #(
  parameter int DW        = 16,
  parameter int ACCW      = 37,
  parameter int OUT_SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 last,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [DW-1:0] out_data,
  output logic                 out_valid
);

  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] prod_x, acc_q, acc_base, acc_nxt, res;
  logic        [DW-1:0]   res_dw;

  assign prod     = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
  assign prod_x   = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
  assign acc_base = clr ? '0 : acc_q;
  assign acc_nxt  = acc_base + prod_x;
  assign res      = acc_nxt >>> OUT_SHIFT;

`ifdef MOD_PORT_SAT_EN
  localparam logic signed [ACCW-1:0] SMAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SMIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  always_comb begin
    res_dw = res[DW-1:0];
    if (res > SMAX)      res_dw = SMAX[DW-1:0];
    else if (res < SMIN) res_dw = SMIN[DW-1:0];
  end
`else
  logic res_hi_unused;
  assign res_hi_unused = ^res[ACCW-1:DW];
  assign res_dw        = res[DW-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= en & last;
      if (en)        acc_q    <= acc_nxt;
      if (en & last) out_data <= res_dw;
    end
  end

endmodule

// File: rtl/mod_port.sv
// Sequential 2D convolution engine (stride 1, zero padding (K-1)/2).
// clk    : clock
// arst_n : synchronous reset, active-high (historic name)
// bus    : mod_port_if.slave -- load port, control, tagged results, status
// Activations and weights are loaded through the a/b handshake while idle.
// On start&data_ready the engine walks y, x, ch and, per output, ky, kx, ci,
// issuing one MAC per cycle. Each result leaves one cycle after its last tap.
// Build option MOD_PORT_SAT_EN (in mod_port_mac): saturating output.
module mod_port
  import mod_port_pkg::*;
#(
  parameter int DATA_WIDTH         = DEFAULT_CFG.data_width,
  parameter int FEATURE_MAP_WIDTH  = DEFAULT_CFG.fm_width,
  parameter int FEATURE_MAP_HEIGHT = DEFAULT_CFG.fm_height,
  parameter int INPUT_NB_CHANNELS  = DEFAULT_CFG.in_ch,
  parameter int OUTPUT_NB_CHANNELS = DEFAULT_CFG.out_ch,
  parameter int KERNEL_SIZE        = DEFAULT_CFG.kernel_size,
  parameter int OUT_SHIFT          = DEFAULT_CFG.out_shift
) (
  input  logic       clk,
  input  logic       arst_n,
  mod_port_if.slave  bus
);

  localparam int DW    = DATA_WIDTH;
  localparam int W     = FEATURE_MAP_WIDTH;
  localparam int H     = FEATURE_MAP_HEIGHT;
  localparam int CIN   = INPUT_NB_CHANNELS;
  localparam int COUT  = OUTPUT_NB_CHANNELS;
  localparam int K     = KERNEL_SIZE;
  localparam int PAD   = (K - 1) / 2;
  localparam int TAPS  = K * K * CIN;
  localparam int ACT_N = W * H * CIN;
  localparam int WGT_N = COUT * K * K * CIN;
  localparam int AAW   = cw(ACT_N);
  localparam int WAW   = cw(WGT_N);
  localparam int XW    = cw(W);
  localparam int YW    = cw(H);
  localparam int CHW   = cw(COUT);
  localparam int KW    = cw(K);
  localparam int CIW   = cw(CIN);
  localparam int ACCW  = 2 * DW + cw(TAPS);

  // ---------------- load port ----------------
  logic                 running_q, ready, wr_go;
  logic signed [DW-1:0] wr_data;
  logic signed [DW-1:0] act_mem [ACT_N];
  logic signed [DW-1:0] wgt_mem [WGT_N];

  assign ready   = ~running_q;
  assign wr_go   = bus.a_valid & ready & (bus.b_zero | (bus.b_valid & ready));
  assign wr_data = bus.b_zero ? '0 : bus.b_input;

  // register files are deliberately not reset: contents survive an abort
  always_ff @(posedge clk) begin
    if (wr_go && bus.int_mem_we && (int'(bus.a_input) < ACT_N))
      act_mem[AAW'(bus.a_input)] <= wr_data;
    if (wr_go && bus.overlap_cache_we && (int'(bus.a_input) < WGT_N))
      wgt_mem[WAW'(bus.a_input)] <= wr_data;
  end

  // ---------------- counters / read path ----------------
  state_t         state_q;
  logic           done_q;
  logic [XW-1:0]  x_q, ox_q;
  logic [YW-1:0]  y_q, oy_q;
  logic [CHW-1:0] ch_q, och_q;
  logic [KW-1:0]  ky_q, kx_q;
  logic [CIW-1:0] ci_q;

  logic ci_end, kx_end, ky_end, ch_end, x_end, y_end;
  logic first_tap, last_tap, last_out;

  assign ci_end    = (ci_q == CIW'(CIN - 1));
  assign kx_end    = (kx_q == KW'(K - 1));
  assign ky_end    = (ky_q == KW'(K - 1));
  assign ch_end    = (ch_q == CHW'(COUT - 1));
  assign x_end     = (x_q  == XW'(W - 1));
  assign y_end     = (y_q  == YW'(H - 1));
  assign first_tap = (ci_q == '0) && (kx_q == '0) && (ky_q == '0);
  assign last_tap  = ci_end & kx_end & ky_end;
  assign last_out  = last_tap & ch_end & x_end & y_end;

  int                   sx, sy;
  logic                 in_map;
  logic [AAW-1:0]       ra;
  logic [WAW-1:0]       rw;
  logic signed [DW-1:0] act_rd, wgt_rd;

  // taps falling outside the map read as zero (padding)
  always_comb begin
    sx     = int'(x_q) + int'(kx_q) - PAD;
    sy     = int'(y_q) + int'(ky_q) - PAD;
    in_map = (sx >= 0) && (sx < W) && (sy >= 0) && (sy < H);
    ra     = in_map ? AAW'(act_addr(sx, sy, int'(ci_q), W, CIN)) : '0;
    rw     = WAW'(wgt_addr(int'(ch_q), int'(ky_q), int'(kx_q), int'(ci_q), K, CIN));
  end

  assign act_rd = in_map ? act_mem[ra] : '0;
  assign wgt_rd = wgt_mem[rw];

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (arst_n) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      {x_q, y_q, ch_q, ky_q, kx_q, ci_q} <= '0;
      {ox_q, oy_q, och_q}                <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start && bus.data_ready) begin
            state_q   <= COMPUTE;
            running_q <= 1'b1;
            {x_q, y_q, ch_q, ky_q, kx_q, ci_q} <= '0;
          end
        end
        COMPUTE: begin
          // tag latched with the final tap so it lines up with the MAC result
          if (last_tap) begin
            ox_q  <= x_q;
            oy_q  <= y_q;
            och_q <= ch_q;
          end
          ci_q <= ci_end ? '0 : ci_q + CIW'(1);
          if (ci_end)                  kx_q <= kx_end ? '0 : kx_q + KW'(1);
          if (ci_end & kx_end)         ky_q <= ky_end ? '0 : ky_q + KW'(1);
          if (last_tap)                ch_q <= ch_end ? '0 : ch_q + CHW'(1);
          if (last_tap & ch_end)       x_q  <= x_end  ? '0 : x_q + XW'(1);
          if (last_tap & ch_end & x_end) y_q <= y_end ? '0 : y_q + YW'(1);
          if (last_out) state_q <= FLUSH;
        end
        // last result is on the bus during FLUSH, still under running
        FLUSH: begin
          state_q   <= DONE;
          running_q <= 1'b0;
          done_q    <= 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------- datapath ----------------
  logic signed [DW-1:0] mac_data;
  logic                 mac_vld;

  mod_port_mac #(
    .DW       (DW),
    .ACCW     (ACCW),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_mac (
    .clk      (clk),
    .rst      (arst_n),
    .clr      (first_tap),
    .en       (state_q == COMPUTE),
    .last     (last_tap),
    .a        (act_rd),
    .b        (wgt_rd),
    .out_data (mac_data),
    .out_valid(mac_vld)
  );

  assign bus.a_ready      = ready;
  assign bus.b_ready      = ready;
  assign bus.output_data  = mac_data;
  assign bus.output_valid = mac_vld;
  assign bus.output_x     = ox_q;
  assign bus.output_y     = oy_q;
  assign bus.output_ch    = och_q;
  assign bus.running      = running_q;
  assign bus.fsm_done     = done_q;

endmodule

// File: tb/tb_mod_port.sv
// Scoreboard bench for mod_port: expected results are queued from a
// behavioural convolution model when a run is started and popped as the
// engine emits tagged results.
`timescale 1ns/1ps
module tb_mod_port;

  localparam int DW    = 16;
  localparam int W     = 8;
  localparam int H     = 8;
  localparam int CIN   = 2;
  localparam int COUT  = 4;
  localparam int K     = 3;
  localparam int SH    = 0;
  localparam int PAD   = 1;
  localparam int TAPS  = K * K * CIN;
  localparam int ACT_N = W * H * CIN;
  localparam int WGT_N = COUT * K * K * CIN;
  localparam int NOUT  = W * H * COUT;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  mod_port_if #(
    .DATA_WIDTH(DW), .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H), .OUTPUT_NB_CHANNELS(COUT)
  ) bus ();

  mod_port #(
    .DATA_WIDTH(DW), .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H),
    .INPUT_NB_CHANNELS(CIN), .OUTPUT_NB_CHANNELS(COUT), .KERNEL_SIZE(K), .OUT_SHIFT(SH)
  ) dut (
    .clk   (clk),
    .arst_n(arst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  logic signed [DW-1:0] act_m [ACT_N];
  logic signed [DW-1:0] wgt_m [WGT_N];
  logic        [DW-1:0] cap   [H][W][COUT];

  typedef struct {
    int          x;
    int          y;
    int          ch;
    logic [DW-1:0] d;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(input int x, input int y, input int ch);
    longint acc;
    longint r;
    acc = 0;
    for (int ky = 0; ky < K; ky++)
      for (int kx = 0; kx < K; kx++)
        for (int ci = 0; ci < CIN; ci++) begin
          int sx, sy;
          sx = x + kx - PAD;
          sy = y + ky - PAD;
          if (sx >= 0 && sx < W && sy >= 0 && sy < H)
            acc += longint'(act_m[(sy * W + sx) * CIN + ci]) *
                   longint'(wgt_m[((ch * K + ky) * K + kx) * CIN + ci]);
        end
    r = acc >>> SH;
`ifdef MOD_PORT_SAT_EN
    if (r > 32767)       r = 32767;
    else if (r < -32768) r = -32768;
`endif
    return r[DW-1:0];
  endfunction

  // one load beat; the bench model tracks what the engine must store
  task automatic wr(input bit we_a, input bit we_w, input int addr, input logic [DW-1:0] d,
                    input bit bz = 1'b0, input bit bv = 1'b1);
    @(negedge clk);
    bus.int_mem_we       = we_a;
    bus.overlap_cache_we = we_w;
    bus.a_input          = DW'(addr);
    bus.b_input          = d;
    bus.b_zero           = bz;
    bus.b_valid          = bv;
    bus.a_valid          = 1'b1;
    if (bz || bv) begin
      if (we_a && addr < ACT_N) act_m[addr] = bz ? '0 : d;
      if (we_w && addr < WGT_N) wgt_m[addr] = bz ? '0 : d;
    end
  endtask

  task automatic idle_bus();
    @(negedge clk);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0; bus.b_zero = 1'b0;
    bus.int_mem_we = 1'b0; bus.overlap_cache_we = 1'b0;
  endtask

  task automatic fill_act(input logic [DW-1:0] v);
    for (int i = 0; i < ACT_N; i++) wr(1'b1, 1'b0, i, v);
  endtask

  task automatic fill_wgt(input logic [DW-1:0] v);
    for (int i = 0; i < WGT_N; i++) wr(1'b0, 1'b1, i, v);
  endtask

  task automatic run(input bit abort);
    int nv, nd, last_v;
    nv = 0; nd = 0; last_v = -1;
    if (!abort)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          for (int ch = 0; ch < COUT; ch++)
            q.push_back('{x, y, ch, model(x, y, ch)});
    @(negedge clk);
    bus.data_ready = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.data_ready = 1'b0;
    chk("running_on", bus.running, 1);
    chk("busy_ready", {bus.a_ready, bus.b_ready}, 0);
    // a load attempt held through the run must never land
    bus.a_valid = 1'b1; bus.b_valid = 1'b1; bus.int_mem_we = 1'b1;
    bus.a_input = '0; bus.b_input = 16'h0007;
    if (abort) begin
      repeat (20) @(negedge clk);
      bus.a_valid = 1'b0; bus.b_valid = 1'b0; bus.int_mem_we = 1'b0;
      arst_n = 1'b1;
      @(negedge clk);
      arst_n = 1'b0;
      chk("abort_running", bus.running, 0);
      repeat (60) begin
        @(negedge clk);
        if (bus.output_valid) nv++;
        if (bus.fsm_done) nd++;
      end
      chk("abort_valids", nv, 0);
      chk("abort_done", nd, 0);
      return;
    end
    for (int cyc = 0; cyc < NOUT * TAPS + 100; cyc++) begin
      @(negedge clk);
      if (bus.output_valid) begin
        if (q.size() == 0) chk("extra_valid", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("result", {16'(bus.output_y), 16'(bus.output_x), 16'(bus.output_ch), bus.output_data},
                        {16'(e.y), 16'(e.x), 16'(e.ch), e.d});
          cap[bus.output_y][bus.output_x][bus.output_ch] = bus.output_data;
        end
        if (last_v >= 0) chk("gap", cyc - last_v, TAPS);
        last_v = cyc;
        nv++;
      end
      if (bus.fsm_done) begin
        nd++;
        chk("done_running", bus.running, 0);
        break;
      end
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0; bus.int_mem_we = 1'b0;
    chk("n_valid", nv, NOUT);
    chk("n_done", nd, 1);
    chk("q_empty", q.size(), 0);
    q.delete();
    @(negedge clk);
    chk("done_pulse", bus.fsm_done, 0);
  endtask

  initial begin
    bus.int_mem_we = 1'b0; bus.overlap_cache_we = 1'b0; bus.b_zero = 1'b0;
    bus.data_ready = 1'b0; bus.start = 1'b0; bus.a_input = '0; bus.a_valid = 1'b0;
    bus.b_input = '0; bus.b_valid = 1'b0;
    arst_n = 1'b1;
    repeat (3) @(negedge clk);
    arst_n = 1'b0;

    // idle after reset
    repeat (5) begin
      @(negedge clk);
      chk("rst_valid", bus.output_valid, 0);
      chk("rst_running", bus.running, 0);
      chk("rst_done", bus.fsm_done, 0);
      chk("rst_ready", {bus.a_ready, bus.b_ready}, 2'b11);
    end
    chk("rst_data", bus.output_data, 0);
    chk("rst_xyc", {bus.output_x, bus.output_y, bus.output_ch}, 0);

    // start without data_ready is ignored
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    chk("start_no_ready", bus.running, 0);

    // delta kernel: centre tap, ci0, ch0
    fill_act(16'd1);
    fill_wgt(16'd0);
    wr(1'b0, 1'b1, ((0 * K + 1) * K + 1) * CIN + 0, 16'd1);
    idle_bus();
    run(1'b0);
    chk("delta_ch0", cap[4][4][0], 1);
    chk("delta_ch1", cap[4][4][1], 0);

    // padding: every weight 1; plus writes that must be dropped
    fill_wgt(16'd1);
    wr(1'b0, 1'b0, 0, 16'h0009);
    wr(1'b1, 1'b0, ACT_N, 16'h0005);
    idle_bus();
    run(1'b0);
    chk("corner", cap[0][0][0], 8);
    chk("interior", cap[3][3][0], 18);

    // b_zero store ignores b_valid/b_input
    wr(1'b1, 1'b0, (2 * W + 2) * CIN + 0, 16'h7FFF, 1'b1, 1'b0);
    idle_bus();
    run(1'b0);
    chk("bzero", cap[2][2][0], 17);

    // overflow
    fill_act(16'h7FFF);
    fill_wgt(16'h7FFF);
    idle_bus();
    run(1'b0);
`ifdef MOD_PORT_SAT_EN
    chk("ovf", cap[3][3][0], 16'h7FFF);
`else
    chk("ovf", cap[3][3][0], 16'h0012);
`endif

    // abort mid-run, then a clean full run
    run(1'b1);
    run(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
